rf_wr_arbiter: RTL and testbench

- Shares the single register-file write port of the 4-bit datapath between two requesters.
  - Requester 0: the core control FSM's writeback (ldr / wb_rd / wb_r0 phases).
  - Requester 1: the program/debug loader that preloads registers.
- Latches the winning request, drives exactly one write cycle, then returns a one-cycle ack. The ack is the wr_ack seen by the control FSM.
- Moore-style controller: all outputs are decoded from state and latched registers only.

---
 rtl/rf_arb_pkg.sv | 18 +
 rtl/rf_wr_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write-port arbiter: state encoding,
// requester IDs and default datapath widths.
package rf_arb_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 2;

    typedef logic [1:0] state_t;

    // Encoding 2'd3 is unused and decodes to IDLE.
    localparam state_t IDLE  = 2'd0;
    localparam state_t WRITE = 2'd1;
    localparam state_t ACK   = 2'd2;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Two-requester arbiter for the single register-file write port (IDLE -> WRITE -> ACK).
// Define RF_ARB_FIXED_PRIO_EN for fixed req0 priority; default is round-robin.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ack,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              grant_id,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              rr_q;
    logic              pick_core;

`ifdef RF_ARB_FIXED_PRIO_EN
    assign rr_q = REQ_CORE;
`else
    logic rr_d;

    // The requester just served loses priority for the next contention.
    always_comb begin
        rr_d = rr_q;
        if (state_q == ACK) begin
            rr_d = ~grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= REQ_CORE;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign pick_core = req0_valid && (!req1_valid || (rr_q == REQ_CORE));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            WRITE: state_d = ACK;
            ACK:   state_d = IDLE;
            default: begin
                state_d = IDLE;
                if (req0_valid || req1_valid) begin
                    state_d = WRITE;
                    if (pick_core) begin
                        grant_d = REQ_CORE;
                        addr_d  = req0_addr;
                        data_d  = req0_data;
                    end else begin
                        grant_d = REQ_LOADER;
                        addr_d  = req1_addr;
                        data_d  = req1_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= REQ_CORE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode purely from registered state, so they are glitch-free Moore outputs.
    assign rf_we    = (state_q == WRITE);
    assign rf_waddr = addr_q;
    assign rf_wdata = data_q;
    assign req0_ack = (state_q == ACK) && (grant_q == REQ_CORE);
    assign req1_ack = (state_q == ACK) && (grant_q == REQ_LOADER);
    assign grant_id = grant_q;
    assign busy     = (state_q == WRITE) || (state_q == ACK);

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed, table-driven bench for rf_wr_arbiter; expectations follow
// RF_ARB_FIXED_PRIO_EN when the bench is built with that macro.
module tb_rf_wr_arbiter;

`ifdef RF_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [1:0] req0_addr  = '0;
    logic [3:0] req0_data  = '0;
    logic       req0_ack;
    logic       req1_valid = 1'b0;
    logic [1:0] req1_addr  = '0;
    logic [3:0] req1_data  = '0;
    logic       req1_ack;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic       grant_id;
    logic       busy;

    int errors = 0;
    int checks = 0;

    rf_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ack   (req0_ack),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ack   (req1_ack),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Output bundle: {we, waddr[1:0], wdata[3:0], ack0, ack1, grant, busy}
    function automatic logic [10:0] o(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                                      input logic a0, input logic a1, input logic g, input logic b);
        return {we, wa, wd, a0, a1, g, b};
    endfunction

    typedef struct {
        logic        v0;
        logic [1:0]  a0;
        logic [3:0]  d0;
        logic        v1;
        logic [1:0]  a1;
        logic [3:0]  d1;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {rf_we, rf_waddr, rf_wdata, req0_ack, req1_ack, grant_id, busy};
        checks++;
        if (act !== exp || (req0_ack && req1_ack)) begin
            errors++;
            $display("FAIL %s: got {we,wa,wd,ack0,ack1,gid,busy}=%b_%h_%h_%b%b%b%b want %b_%h_%h_%b%b%b%b",
                     name, act[10], act[9:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[10], exp[9:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: we=%b wa=%0d wd=%h ack0=%b ack1=%b gid=%b busy=%b",
                     name, act[10], act[9:8], act[7:4], act[3], act[2], act[1], act[0]);
        end
    endtask

    task automatic step(input logic v0, input logic [1:0] a0, input logic [3:0] d0,
                        input logic v1, input logic [1:0] a1, input logic [3:0] d1);
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single core write r2=A, then loader one-cycle request r3=7 with data
        // changed to F after the grant, then sustained contention r1=3 / r2=5.
        vecs[0]  = '{1, 2, 4'hA, 0, 0, 4'h0, o(1, 2, 4'hA, 0, 0, 0, 1)};
        vecs[1]  = '{1, 2, 4'hA, 0, 0, 4'h0, o(0, 2, 4'hA, 1, 0, 0, 1)};
        vecs[2]  = '{0, 2, 4'hA, 0, 0, 4'h0, o(0, 2, 4'hA, 0, 0, 0, 0)};
        vecs[3]  = '{0, 0, 4'h0, 1, 3, 4'h7, o(1, 3, 4'h7, 0, 0, 1, 1)};
        vecs[4]  = '{0, 0, 4'h0, 0, 3, 4'hF, o(0, 3, 4'h7, 0, 1, 1, 1)};
        vecs[5]  = '{0, 0, 4'h0, 0, 3, 4'hF, o(0, 3, 4'h7, 0, 0, 1, 0)};
        vecs[6]  = '{1, 1, 4'h3, 1, 2, 4'h5, o(1, 1, 4'h3, 0, 0, 0, 1)};
        vecs[7]  = '{1, 1, 4'h3, 1, 2, 4'h5, o(0, 1, 4'h3, 1, 0, 0, 1)};
        vecs[8]  = '{1, 1, 4'h3, 1, 2, 4'h5, o(0, 1, 4'h3, 0, 0, 0, 0)};
        vecs[9]  = '{1, 1, 4'h3, 1, 2, 4'h5,
                     FIXED ? o(1, 1, 4'h3, 0, 0, 0, 1) : o(1, 2, 4'h5, 0, 0, 1, 1)};
        vecs[10] = '{1, 1, 4'h3, 1, 2, 4'h5,
                     FIXED ? o(0, 1, 4'h3, 1, 0, 0, 1) : o(0, 2, 4'h5, 0, 1, 1, 1)};
        vecs[11] = '{1, 1, 4'h3, 1, 2, 4'h5,
                     FIXED ? o(0, 1, 4'h3, 0, 0, 0, 0) : o(0, 2, 4'h5, 0, 0, 1, 0)};
        vecs[12] = '{1, 1, 4'h3, 1, 2, 4'h5, o(1, 1, 4'h3, 0, 0, 0, 1)};
        vecs[13] = '{1, 1, 4'h3, 1, 2, 4'h5, o(0, 1, 4'h3, 1, 0, 0, 1)};
        vecs[14] = '{0, 1, 4'h3, 0, 2, 4'h5, o(0, 1, 4'h3, 0, 0, 0, 0)};

        // Reset for two cycles, then ten idle cycles with everything low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 4'h0, 0, 0, 4'h0);
            check($sformatf("idle%0d", i), o(0, 0, 4'h0, 0, 0, 0, 0));
        end

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset during WRITE: abort with no ack, then priority restarts at req0.
        step(0, 0, 4'h0, 1, 0, 4'h9);
        check("mid_write", o(1, 0, 4'h9, 0, 0, 1, 1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst", o(0, 0, 4'h0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", o(0, 0, 4'h0, 0, 0, 0, 0));
        step(1, 0, 4'h6, 1, 0, 4'h9);
        check("rst_regrant_r0", o(1, 0, 4'h6, 0, 0, 0, 1));
        step(0, 0, 4'h6, 1, 0, 4'h9);
        check("rst_regrant_ack", o(0, 0, 4'h6, 1, 0, 0, 1));
        step(0, 0, 4'h6, 1, 0, 4'h9);
        check("rst_regrant_idle", o(0, 0, 4'h6, 0, 0, 0, 0));
        step(0, 0, 4'h0, 1, 0, 4'h9);
        check("loader_after", o(1, 0, 4'h9, 0, 0, 1, 1));
        step(0, 0, 4'h0, 0, 0, 4'h9);
        check("loader_after_ack", o(0, 0, 4'h9, 0, 1, 1, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
